instr_fetch_unit: RTL and testbench

//  Fetch stage of the 8-bit mini CPU: holds the program counter and fetches 12-bit

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit mini CPU.
package cpu_pkg;

  localparam int unsigned IW  = 12;
  localparam int unsigned AW  = 8;
  localparam int unsigned OPW = 4;

  // Fetch-stage sequencing states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Opcodes carried in ir[IW-1:IW-OPW], shared with the decode stage
  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_STA = 4'h2;
  localparam logic [OPW-1:0] OP_ADD = 4'h3;
  localparam logic [OPW-1:0] OP_SUB = 4'h4;
  localparam logic [OPW-1:0] OP_AND = 4'h5;
  localparam logic [OPW-1:0] OP_OR  = 4'h6;
  localparam logic [OPW-1:0] OP_XOR = 4'h7;
  localparam logic [OPW-1:0] OP_JMP = 4'h8;
  localparam logic [OPW-1:0] OP_JZ  = 4'h9;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, req/ack instruction fetch, and an
// instruction register presented downstream with a valid/ready handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned    IW       = cpu_pkg::IW,
  parameter int unsigned    AW       = cpu_pkg::AW,
  parameter int unsigned    OPW      = cpu_pkg::OPW,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [AW-1:0] pc
);

  // The instruction word must split exactly into opcode and operand fields
  if (IW != OPW + AW) begin : g_width_check
    $error("instr_fetch_unit: IW must equal OPW + AW");
  end

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          valid_q, valid_d;
  logic          flush_q, flush_d;
  logic          req_q;
  logic          hold_addr;

  // State and datapath registers; mem_req is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      req_q   <= (state_d == S_REQ);
    end
  end

  // Next-state, PC update and instruction capture; jump_en dominates
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    valid_d   = valid_q;
    flush_d   = flush_q;
    hold_addr = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (jump_en) begin
          pc_d = jump_addr;
        end else if (!halt) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (jump_en) begin
          pc_d = jump_addr;
          if (mem_ack) begin
            // Response to the stale address arrives now: drop it, re-request
            flush_d = 1'b0;
            state_d = halt ? S_IDLE : S_REQ;
          end else begin
            // Request must stay stable; remember to discard its response
            flush_d   = 1'b1;
            hold_addr = 1'b1;
          end
        end else if (mem_ack) begin
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = halt ? S_IDLE : S_REQ;
          end else begin
            ir_d    = mem_rdata;
            valid_d = 1'b1;
            pc_d    = pc_q + AW'(1);
            state_d = S_HOLD;
          end
        end else begin
          hold_addr = 1'b1;
        end
      end

      S_HOLD: begin
        if (jump_en) begin
          pc_d    = jump_addr;
          valid_d = 1'b0;
          state_d = halt ? S_IDLE : S_REQ;
        end else if (ir_ready) begin
          valid_d = 1'b0;
          state_d = halt ? S_IDLE : S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        flush_d = 1'b0;
      end
    endcase

    // Fetch address tracks the PC except while a request is outstanding
    addr_d = hold_addr ? addr_q : pc_d;
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign ir       = ir_q;
  assign ir_valid = valid_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async-reset sequence,
// and randomized traffic against a transaction-level reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic [11:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.IW(12), .AW(8), .OPW(4), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halt      (halt),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc        (pc)
  );

  typedef struct {
    logic        halt;
    logic        jump;
    logic [7:0]  jaddr;
    logic        ack;
    logic [11:0] rdata;
    logic        ready;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [11:0] e_ir;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic h, logic j, logic [7:0] ja, logic a,
                              logic [11:0] rd, logic rdy, logic er,
                              logic [7:0] ea, logic ev, logic [11:0] ei,
                              logic [7:0] ep);
    vec_t v;
    v.halt = h; v.jump = j; v.jaddr = ja; v.ack = a; v.rdata = rd;
    v.ready = rdy; v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_ir = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic er, input logic [7:0] ea,
                           input logic ev, input logic [11:0] ei, input logic [7:0] ep);
    chk({tag, ".mem_req"},  32'(mem_req),  32'(er));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(ev));
    chk({tag, ".ir"},       32'(ir),       32'(ei));
    chk({tag, ".pc"},       32'(pc),       32'(ep));
  endtask

  task automatic drive(input logic h, input logic j, input logic [7:0] ja,
                       input logic a, input logic [11:0] rd, input logic rdy);
    halt = h; jump_en = j; jump_addr = ja; mem_ack = a; mem_rdata = rd; ir_ready = rdy;
  endtask

  // Reference model: whether a fetch is outstanding, whether an instruction
  // is held for downstream, and whether the outstanding fetch is stale.
  logic        m_busy, m_have, m_flush;
  logic [7:0]  m_pc, m_addr;
  logic [11:0] m_ir;

  task automatic model_reset();
    m_busy = 0; m_have = 0; m_flush = 0; m_pc = 8'h00; m_addr = 8'h00; m_ir = '0;
  endtask

  task automatic model_step(input logic h, input logic j, input logic [7:0] ja,
                            input logic a, input logic [11:0] rd, input logic rdy);
    logic was_busy;
    was_busy = m_busy;
    if (j) begin
      if (m_busy) begin
        if (a) begin m_flush = 0; m_busy = !h; end
        else m_flush = 1;
      end else if (m_have) begin
        m_have = 0; m_busy = !h;
      end
      m_pc = ja;
    end else if (m_busy && a) begin
      if (m_flush) begin
        m_flush = 0; m_busy = !h;
      end else begin
        m_ir = rd; m_have = 1; m_busy = 0; m_pc = m_pc + 8'd1;
      end
    end else if (m_have) begin
      if (rdy) begin m_have = 0; m_busy = !h; end
    end else if (!m_busy) begin
      m_busy = !h;
    end
    // An unanswered request keeps its address; otherwise it follows the PC
    if (!(was_busy && !a)) m_addr = m_pc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 12'h000, 0);

    //        halt jmp jaddr  ack rdata    rdy  req addr  vld ir       pc
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 0,   1, 8'h00, 0, 12'h000, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 1, 12'h3A5, 0,   0, 8'h01, 1, 12'h3A5, 8'h01));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 0, 0, 8'h01, 1, 12'h3A5, 8'h01));
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 1,   1, 8'h01, 0, 12'h3A5, 8'h01));
    tbl.push_back(mk(0, 0, 8'h00, 1, 12'h7C1, 0,   0, 8'h02, 1, 12'h7C1, 8'h02));
    tbl.push_back(mk(0, 1, 8'h20, 0, 12'h000, 1,   1, 8'h20, 0, 12'h7C1, 8'h20));
    tbl.push_back(mk(0, 0, 8'h00, 1, 12'h111, 0,   0, 8'h21, 1, 12'h111, 8'h21));
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 1,   1, 8'h21, 0, 12'h111, 8'h21));
    tbl.push_back(mk(0, 1, 8'h40, 0, 12'h000, 0,   1, 8'h21, 0, 12'h111, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 0,   1, 8'h21, 0, 12'h111, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 0,   1, 8'h21, 0, 12'h111, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 1, 12'hBAD, 0,   1, 8'h40, 0, 12'h111, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 1, 12'h222, 0,   0, 8'h41, 1, 12'h222, 8'h41));
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 1,   1, 8'h41, 0, 12'h222, 8'h41));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 12'h333, 0,   1, 8'hFF, 0, 12'h222, 8'hFF));
    tbl.push_back(mk(1, 0, 8'h00, 1, 12'h444, 0,   0, 8'h00, 1, 12'h444, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 1,   0, 8'h00, 0, 12'h444, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 0,   0, 8'h00, 0, 12'h444, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 0, 12'h000, 0,   1, 8'h00, 0, 12'h444, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 0,   1, 8'h00, 0, 12'h444, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 1, 12'h555, 0,   0, 8'h01, 1, 12'h555, 8'h01));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 0,   0, 8'h01, 1, 12'h555, 8'h01));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 1,   0, 8'h01, 0, 12'h555, 8'h01));
    tbl.push_back(mk(1, 1, 8'h80, 0, 12'h000, 0,   0, 8'h80, 0, 12'h555, 8'h80));
    tbl.push_back(mk(0, 0, 8'h00, 1, 12'hEEE, 1,   1, 8'h80, 0, 12'h555, 8'h80));

    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 8'h00, 0, 12'h000, 8'h00);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].halt, tbl[k].jump, tbl[k].jaddr, tbl[k].ack, tbl[k].rdata, tbl[k].ready);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_addr,
                tbl[k].e_valid, tbl[k].e_ir, tbl[k].e_pc);
    end

    // Asynchronous reset while a request is outstanding, away from any edge
    drive(0, 0, 8'h00, 0, 12'h000, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 8'h00, 0, 12'h000, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      logic        h, j, a, rdy;
      logic [7:0]  ja;
      logic [11:0] rd;
      h   = ($urandom_range(0, 99) < 20);
      j   = ($urandom_range(0, 99) < 8);
      ja  = 8'($urandom);
      a   = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
      rd  = 12'($urandom);
      rdy = ($urandom_range(0, 99) < 50);
      drive(h, j, ja, a, rd, rdy);
      @(posedge clk);
      model_step(h, j, ja, a, rd, rdy);
      #1;
      check_all($sformatf("rnd%0d", i), m_busy, m_addr, m_have, m_ir, m_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
